// File: rtl/control_unit.sv
// Multi-cycle MIPS-subset control unit: a Moore FSM stepping IF/ID/EXE/MEM/WB
// and decoding the held opcode into datapath selects and enables.
module control_unit (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] Opcode,
   input  logic       zero,
   input  logic       sign,
   output logic       PCWre,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [2:0] ALUop,
   output logic       ExtSel,
   output logic       InsMemRW,
   output logic       IRWre,
   output logic       RegWre,
   output logic [1:0] RegDst,
   output logic       WrRegDSrc,
   output logic       DBDataSrc,
   output logic       mRD,
   output logic       mWR,
   output logic [1:0] PCSrc,
   output logic [2:0] State
);

   localparam logic [5:0] OpAdd   = 6'b000000;
   localparam logic [5:0] OpSub   = 6'b000001;
   localparam logic [5:0] OpAddiu = 6'b000010;
   localparam logic [5:0] OpAnd   = 6'b010000;
   localparam logic [5:0] OpAndi  = 6'b010001;
   localparam logic [5:0] OpOri   = 6'b010010;
   localparam logic [5:0] OpXori  = 6'b010011;
   localparam logic [5:0] OpOr    = 6'b010100;
   localparam logic [5:0] OpSll   = 6'b011000;
   localparam logic [5:0] OpSlti  = 6'b100110;
   localparam logic [5:0] OpSlt   = 6'b100111;
   localparam logic [5:0] OpSw    = 6'b110000;
   localparam logic [5:0] OpLw    = 6'b110001;
   localparam logic [5:0] OpBeq   = 6'b110100;
   localparam logic [5:0] OpBne   = 6'b110101;
   localparam logic [5:0] OpBltz  = 6'b110110;
   localparam logic [5:0] OpJ     = 6'b111000;
   localparam logic [5:0] OpJr    = 6'b111001;
   localparam logic [5:0] OpJal   = 6'b111010;
   localparam logic [5:0] OpHalt  = 6'b111111;

   typedef enum logic [2:0] {
      StIf  = 3'b000,
      StId  = 3'b001,
      StExe = 3'b010,
      StMem = 3'b011,
      StWb  = 3'b100
   } state_e;

   state_e     r_state;
   state_e     w_state_next;
   logic [2:0] w_alu_op;
   logic       w_src_a;
   logic       w_src_b;
   logic       w_ext_sel;
   logic       w_rtype;
   logic       w_exec;
   logic       w_branch;
   logic       w_taken;

   // Opcode decode: ALU function, operand selects, and whether the op runs through EXE
   always_comb begin
      w_alu_op  = 3'b000;
      w_src_a   = 1'b0;
      w_src_b   = 1'b0;
      w_ext_sel = 1'b1;
      w_rtype   = 1'b0;
      w_exec    = 1'b1;
      case (Opcode)
         OpAdd:   w_rtype = 1'b1;
         OpSub:   begin w_alu_op = 3'b001; w_rtype = 1'b1; end
         OpAddiu: w_src_b = 1'b1;
         OpAnd:   begin w_alu_op = 3'b100; w_rtype = 1'b1; end
         OpAndi:  begin w_alu_op = 3'b100; w_src_b = 1'b1; w_ext_sel = 1'b0; end
         OpOri:   begin w_alu_op = 3'b011; w_src_b = 1'b1; w_ext_sel = 1'b0; end
         OpXori:  begin w_alu_op = 3'b111; w_src_b = 1'b1; w_ext_sel = 1'b0; end
         OpOr:    begin w_alu_op = 3'b011; w_rtype = 1'b1; end
         OpSll:   begin w_alu_op = 3'b010; w_rtype = 1'b1; w_src_a = 1'b1; end
         OpSlti:  begin w_alu_op = 3'b110; w_src_b = 1'b1; end
         OpSlt:   begin w_alu_op = 3'b110; w_rtype = 1'b1; end
         OpSw, OpLw:             w_src_b = 1'b1;
         OpBeq, OpBne, OpBltz:   w_alu_op = 3'b001;
         default: w_exec = 1'b0;
      endcase
   end

   assign w_branch = (Opcode == OpBeq) || (Opcode == OpBne) || (Opcode == OpBltz);
   assign w_taken  = ((Opcode == OpBeq) && zero) || ((Opcode == OpBne) && !zero) ||
                     ((Opcode == OpBltz) && sign);

   // Next-state and Moore outputs; reset overrides everything in the same cycle
   always_comb begin
      w_state_next = StIf;
      PCWre        = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 1'b0;
      ALUop        = 3'b000;
      ExtSel       = 1'b0;
      InsMemRW     = 1'b0;
      IRWre        = 1'b0;
      RegWre       = 1'b0;
      RegDst       = 2'b00;
      WrRegDSrc    = 1'b0;
      DBDataSrc    = 1'b0;
      mRD          = 1'b0;
      mWR          = 1'b0;
      PCSrc        = 2'b00;

      // Datapath selects stay constant for the whole instruction after fetch
      if (r_state inside {StId, StExe, StMem, StWb}) begin
         ALUop     = w_alu_op;
         ALUSrcA   = w_src_a;
         ALUSrcB   = w_src_b;
         ExtSel    = w_ext_sel;
         DBDataSrc = (Opcode == OpLw);
         RegDst    = (Opcode == OpJal) ? 2'b00 : (w_rtype ? 2'b10 : 2'b01);
      end

      case (r_state)
         StIf: begin
            InsMemRW     = 1'b1;
            IRWre        = 1'b1;
            w_state_next = StId;
         end
         StId: begin
            if (Opcode == OpJ) begin
               PCWre = 1'b1;
               PCSrc = 2'b11;
            end else if (Opcode == OpJr) begin
               PCWre = 1'b1;
               PCSrc = 2'b10;
            end else if (Opcode == OpJal) begin
               PCWre     = 1'b1;
               PCSrc     = 2'b11;
               RegWre    = 1'b1;
               WrRegDSrc = 1'b0;
            end else if (Opcode == OpHalt) begin
               w_state_next = StId;
            end else if (w_exec) begin
               w_state_next = StExe;
            end else begin
               // Unknown opcode: retire as a NOP
               PCWre = 1'b1;
            end
         end
         StExe: begin
            if (w_branch) begin
               PCWre = 1'b1;
               PCSrc = w_taken ? 2'b01 : 2'b00;
            end else if ((Opcode == OpSw) || (Opcode == OpLw)) begin
               w_state_next = StMem;
            end else begin
               w_state_next = StWb;
            end
         end
         StMem: begin
            if (Opcode == OpSw) begin
               mWR   = 1'b1;
               PCWre = 1'b1;
            end else if (Opcode == OpLw) begin
               mRD          = 1'b1;
               w_state_next = StWb;
            end
         end
         StWb: begin
            RegWre    = 1'b1;
            WrRegDSrc = 1'b1;
            PCWre     = 1'b1;
         end
         default: ;
      endcase

      if (Reset) begin
         w_state_next = StIf;
         PCWre        = 1'b0;
         ALUSrcA      = 1'b0;
         ALUSrcB      = 1'b0;
         ALUop        = 3'b000;
         ExtSel       = 1'b0;
         InsMemRW     = 1'b0;
         IRWre        = 1'b0;
         RegWre       = 1'b0;
         RegDst       = 2'b00;
         WrRegDSrc    = 1'b0;
         DBDataSrc    = 1'b0;
         mRD          = 1'b0;
         mWR          = 1'b0;
         PCSrc        = 2'b00;
      end
   end

   // State register with synchronous reset to IF
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state <= StIf;
      end else begin
         r_state <= w_state_next;
      end
   end

   assign State = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction cycle traces from a
// behavioural model, plus reset, halt and mid-instruction reset scenarios.
module tb_control_unit;

   localparam logic [5:0] OpAdd   = 6'b000000;
   localparam logic [5:0] OpSub   = 6'b000001;
   localparam logic [5:0] OpAddiu = 6'b000010;
   localparam logic [5:0] OpAnd   = 6'b010000;
   localparam logic [5:0] OpAndi  = 6'b010001;
   localparam logic [5:0] OpOri   = 6'b010010;
   localparam logic [5:0] OpXori  = 6'b010011;
   localparam logic [5:0] OpOr    = 6'b010100;
   localparam logic [5:0] OpSll   = 6'b011000;
   localparam logic [5:0] OpSlti  = 6'b100110;
   localparam logic [5:0] OpSlt   = 6'b100111;
   localparam logic [5:0] OpSw    = 6'b110000;
   localparam logic [5:0] OpLw    = 6'b110001;
   localparam logic [5:0] OpBeq   = 6'b110100;
   localparam logic [5:0] OpBne   = 6'b110101;
   localparam logic [5:0] OpBltz  = 6'b110110;
   localparam logic [5:0] OpJ     = 6'b111000;
   localparam logic [5:0] OpJr    = 6'b111001;
   localparam logic [5:0] OpJal   = 6'b111010;
   localparam logic [5:0] OpHalt  = 6'b111111;
   localparam logic [5:0] OpNop   = 6'b000011;

   localparam int KAlu = 0, KSw = 1, KLw = 2, KBr = 3, KJmp = 4, KNop = 5;

   typedef struct packed {
      logic [2:0] state;
      logic       pcwre;
      logic       insmemrw;
      logic       irwre;
      logic       regwre;
      logic       mrd;
      logic       mwr;
      logic [1:0] pcsrc;
      logic       wrregdsrc;
      logic       alusrca;
      logic       alusrcb;
      logic [2:0] aluop;
      logic       extsel;
      logic       dbdatasrc;
      logic [1:0] regdst;
   } outs_t;

   typedef struct packed {
      outs_t exp;
      outs_t msk;
   } step_t;

   logic       CLK, Reset, zero, sign;
   logic [5:0] Opcode;
   logic       PCWre, ALUSrcA, ALUSrcB, ExtSel, InsMemRW, IRWre, RegWre;
   logic       WrRegDSrc, DBDataSrc, mRD, mWR;
   logic [2:0] ALUop, State;
   logic [1:0] RegDst, PCSrc;
   outs_t      got;
   step_t      q[$];
   int         errors = 0;
   int         checks = 0;

   control_unit dut (
      .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .zero(zero), .sign(sign),
      .PCWre(PCWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
      .ExtSel(ExtSel), .InsMemRW(InsMemRW), .IRWre(IRWre), .RegWre(RegWre),
      .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc), .mRD(mRD),
      .mWR(mWR), .PCSrc(PCSrc), .State(State)
   );

   assign got = {State, PCWre, InsMemRW, IRWre, RegWre, mRD, mWR, PCSrc, WrRegDSrc,
                 ALUSrcA, ALUSrcB, ALUop, ExtSel, DBDataSrc, RegDst};

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   function automatic int kind_of(input logic [5:0] op);
      if (op inside {OpAdd, OpSub, OpAddiu, OpAnd, OpAndi, OpOri, OpXori, OpOr, OpSll,
                     OpSlti, OpSlt}) return KAlu;
      if (op == OpSw) return KSw;
      if (op == OpLw) return KLw;
      if (op inside {OpBeq, OpBne, OpBltz}) return KBr;
      if (op inside {OpJ, OpJr, OpJal}) return KJmp;
      return KNop;
   endfunction

   function automatic logic [2:0] alu_code(input logic [5:0] op);
      if (op inside {OpSub, OpBeq, OpBne, OpBltz}) return 3'b001;
      if (op == OpSll) return 3'b010;
      if (op inside {OpOr, OpOri}) return 3'b011;
      if (op inside {OpAnd, OpAndi}) return 3'b100;
      if (op inside {OpSlti, OpSlt}) return 3'b110;
      if (op == OpXori) return 3'b111;
      return 3'b000;
   endfunction

   // Build the expected per-cycle trace of one instruction into q
   function automatic void build(input logic [5:0] op, input logic z, input logic s);
      int         k;
      int         seq[$];
      logic [1:0] last_src;
      outs_t      e, m;
      k = kind_of(op);
      case (k)
         KAlu:    seq = '{0, 1, 2, 4};
         KSw:     seq = '{0, 1, 2, 3};
         KLw:     seq = '{0, 1, 2, 3, 4};
         KBr:     seq = '{0, 1, 2};
         default: seq = '{0, 1};
      endcase
      last_src = 2'b00;
      if (op == OpJ || op == OpJal) last_src = 2'b11;
      if (op == OpJr) last_src = 2'b10;
      if ((op == OpBeq && z) || (op == OpBne && !z) || (op == OpBltz && s)) last_src = 2'b01;
      q.delete();
      for (int i = 0; i < seq.size(); i++) begin
         e = '0;
         m = '0;
         e.state = seq[i][2:0];
         m.state = '1;
         m.pcwre = 1'b1; m.insmemrw = 1'b1; m.irwre = 1'b1;
         m.regwre = 1'b1; m.mrd = 1'b1; m.mwr = 1'b1;
         if (seq[i] == 0) begin e.insmemrw = 1'b1; e.irwre = 1'b1; end
         if (i == seq.size() - 1) begin e.pcwre = 1'b1; m.pcsrc = '1; e.pcsrc = last_src; end
         if (seq[i] == 3) begin e.mrd = (k == KLw); e.mwr = (k == KSw); end
         if (seq[i] == 4) begin e.regwre = 1'b1; m.wrregdsrc = 1'b1; e.wrregdsrc = 1'b1; end
         if (op == OpJal && seq[i] == 1) begin
            e.regwre = 1'b1; m.wrregdsrc = 1'b1; m.regdst = '1; e.regdst = 2'b00;
         end
         if (seq[i] != 0 && k inside {KAlu, KSw, KLw, KBr}) begin
            m.aluop = '1;      e.aluop = alu_code(op);
            m.alusrca = 1'b1;  e.alusrca = (op == OpSll);
            m.alusrcb = 1'b1;
            e.alusrcb = op inside {OpAddiu, OpAndi, OpOri, OpXori, OpSlti, OpSw, OpLw};
            m.extsel = 1'b1;   e.extsel = !(op inside {OpAndi, OpOri, OpXori});
            m.dbdatasrc = 1'b1; e.dbdatasrc = (op == OpLw);
            if (k == KAlu || k == KLw) begin
               m.regdst = '1;
               e.regdst = (op inside {OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpSll}) ? 2'b10 : 2'b01;
            end
         end
         q.push_back('{exp: e, msk: m});
      end
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         Opcode = 6'($urandom_range(0, 63));
         @(negedge CLK);
         checks++;
         if ({State, PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, PCSrc, ALUop} !== 14'b0) begin
            errors++;
            $display("FAIL reset_outputs: got state=%b en=%b%b%b%b%b%b pcsrc=%b aluop=%b, want all 0",
                     State, PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, PCSrc, ALUop);
         end
      end
      @(posedge CLK); #1;
      Reset = 1'b0;
   endtask

   task automatic test_directed();
      logic [7:0] tbl[6];
      tbl = '{{OpAdd, 2'b00}, {OpLw, 2'b00}, {OpBeq, 2'b10}, {OpBne, 2'b10},
              {OpJal, 2'b00}, {OpNop, 2'b01}};
      for (int t = 0; t < 6; t++) begin
         Opcode = tbl[t][7:2];
         zero   = tbl[t][1];
         sign   = tbl[t][0];
         build(Opcode, zero, sign);
         for (int c = 0; c < q.size(); c++) begin
            @(negedge CLK);
            checks++;
            if (((got ^ q[c].exp) & q[c].msk) !== '0) begin
               errors++;
               $display("FAIL directed_trace op=%b cyc=%0d: got=%h want=%h mask=%h",
                        Opcode, c, got, q[c].exp, q[c].msk);
            end
            @(posedge CLK); #1;
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] pool[19];
      pool = '{OpAdd, OpSub, OpAddiu, OpAnd, OpAndi, OpOri, OpXori, OpOr, OpSll, OpSlti,
               OpSlt, OpSw, OpLw, OpBeq, OpBne, OpBltz, OpJ, OpJr, OpJal};
      for (int t = 0; t < 80; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            Opcode = 6'($urandom_range(0, 62));
         end else begin
            Opcode = pool[$urandom_range(0, 18)];
         end
         zero = 1'($urandom_range(0, 1));
         sign = 1'($urandom_range(0, 1));
         build(Opcode, zero, sign);
         for (int c = 0; c < q.size(); c++) begin
            @(negedge CLK);
            checks++;
            if (((got ^ q[c].exp) & q[c].msk) !== '0) begin
               errors++;
               $display("FAIL random_trace op=%b z=%b s=%b cyc=%0d: got=%h want=%h mask=%h",
                        Opcode, zero, sign, c, got, q[c].exp, q[c].msk);
            end
            @(posedge CLK); #1;
         end
      end
   endtask

   task automatic test_halt();
      Opcode = OpHalt;
      @(negedge CLK);
      checks++;
      if (State !== 3'b000) begin
         errors++;
         $display("FAIL halt_fetch: got state=%b want 000", State);
      end
      @(posedge CLK); #1;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         checks++;
         if ({State, PCWre, RegWre, mRD, mWR} !== 7'b0010000) begin
            errors++;
            $display("FAIL halt_hold cyc=%0d: got state=%b pcwre=%b regwre=%b want 001/0/0",
                     i, State, PCWre, RegWre);
         end
         @(posedge CLK); #1;
      end
      Reset = 1'b1;
      @(negedge CLK);
      checks++;
      if ({PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, PCSrc, ALUop} !== 11'b0) begin
         errors++;
         $display("FAIL halt_reset_outputs: got pcwre=%b irwre=%b insmem=%b, want 0",
                  PCWre, IRWre, InsMemRW);
      end
      @(posedge CLK); #1;
      Reset = 1'b0;
      @(negedge CLK);
      checks++;
      if ({State, InsMemRW, IRWre, PCWre} !== 6'b000110) begin
         errors++;
         $display("FAIL halt_release: got state=%b insmem=%b irwre=%b pcwre=%b want 000/1/1/0",
                  State, InsMemRW, IRWre, PCWre);
      end
      Opcode = OpNop;
      @(posedge CLK); #1;
      @(negedge CLK);
      checks++;
      if ({State, PCWre} !== 4'b0011) begin
         errors++;
         $display("FAIL nop_after_halt: got state=%b pcwre=%b want 001/1", State, PCWre);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_midop_reset();
      Opcode = OpSw;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         checks++;
         if (State !== 3'(c)) begin
            errors++;
            $display("FAIL sw_walk cyc=%0d: got state=%b want %b", c, State, 3'(c));
         end
         @(posedge CLK); #1;
      end
      Reset = 1'b1;
      @(negedge CLK);
      checks++;
      if ({State, mWR, PCWre} !== 5'b01100) begin
         errors++;
         $display("FAIL mem_reset: got state=%b mwr=%b pcwre=%b want 011/0/0", State, mWR, PCWre);
      end
      @(posedge CLK); #1;
      Reset = 1'b0;
      @(negedge CLK);
      checks++;
      if ({State, InsMemRW, IRWre, mWR} !== 6'b000110) begin
         errors++;
         $display("FAIL mem_reset_release: got state=%b insmem=%b irwre=%b mwr=%b want 000/1/1/0",
                  State, InsMemRW, IRWre, mWR);
      end
      Opcode = OpNop;
      @(posedge CLK); #1;
   endtask

   initial begin
      Reset  = 1'b1;
      Opcode = 6'b0;
      zero   = 1'b0;
      sign   = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_halt();
      test_midop_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL provide these ports (name  direction  width  meaning):
- CLK  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- Opcode  in  6  IR[31:26], held stable by IR from ID onward.
- zero  in  1  ALU Result==0.
- sign  in  1  ALU Result negative.
- PCWre  out  1  PC load enable.
- ALUSrcA  out  1  ALU A select: 1=Sa, 0=ReadData1.
- ALUSrcB  out  1  ALU B select: 1=Ext, 0=ReadData2.
- ALUop  out  3  ALU function code.
- ExtSel  out  1  1=sign-extend imm16, 0=zero-extend.
- InsMemRW  out  1  instruction memory read.
- IRWre  out  1  IR load enable.
- RegWre  out  1  register file write enable.
- RegDst  out  2  write reg: 00=$31, 01=rt, 10=rd.
- WrRegDSrc  out  1  write data: 0=PC+4, 1=DB.
- DBDataSrc  out  1  DB: 0=ALU result, 1=memory data.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- PCSrc  out  2  00=PC+4, 01=branch target, 10=rs (jr), 11=jump target.
- State  out  3  current state, for debug.

Function
REQ-003 SHALL implement Moore FSM, 3-bit state register: IF=000, ID=001, EXE=010, MEM=011, WB=100; codes 101-111 SHALL go to IF next cycle with all enables 0.
REQ-004 SHALL decode opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, xori 010011, or 010100, sll 011000, slti 100110, slt 100111, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111. Any other opcode SHALL be a NOP: IF->ID->IF with PCWre=1 in ID.
REQ-005 SHALL drive IF: InsMemRW=1, IRWre=1, all other enables 0; next state ID.
REQ-006 ID transitions: j/jr/jal -> IF with PCWre=1 and PCSrc 11/10/11; jal additionally RegWre=1, RegDst=00, WrRegDSrc=0. halt -> ID with PCWre=0; held until Reset. All others -> EXE.
REQ-007 EXE: SHALL drive ALUop per opcode: add/addiu/sw/lw 000; sub/beq/bne/bltz 001; sll 010; or/ori 011; and/andi 100; slti/slt 110; xori 111.
REQ-008 SHALL set ALUSrcA=1 only for sll and ALUSrcB=1 for addiu/andi/ori/xori/slti/sw/lw. ExtSel=0 for andi/ori/xori; otherwise 1.
REQ-009 Branches in EXE SHALL assert PCWre=1 and then go to IF. PCSrc=01 when taken, else 00. beq taken iff zero=1; bne iff zero=0; bltz iff sign=1.
REQ-010 EXE next state: sw/lw -> MEM; all remaining ALU ops -> WB.
REQ-011 MEM: sw SHALL assert mWR=1 and PCWre=1, then go to IF; lw SHALL assert mRD=1, then go to WB.
REQ-012 WB: SHALL assert RegWre=1, WrRegDSrc=1 and PCWre=1 with PCSrc=00, then go to IF. RegDst=10 for R-type (add/sub/and/or/slt/sll), 01 otherwise. DBDataSrc=1 for lw only.
REQ-013 ALUop/ALUSrcA/ALUSrcB/ExtSel/DBDataSrc/RegDst SHALL be held from ID through WB of the same instruction.
REQ-014 PCWre SHALL be 1 in exactly one cycle per instruction; RegWre, mWR and mRD SHALL never be 1 in IF.

Reset
REQ-015 Reset=1 at a clock edge SHALL force State=IF regardless of current state, including mid-instruction and halt.
REQ-016 While Reset=1, all enables (PCWre, IRWre, InsMemRW, RegWre, mRD, mWR) SHALL be 0, PCSrc=00, ALUop=000. IF outputs SHALL begin the first cycle after Reset deasserts.

Verification
REQ-017 add: Reset, then Opcode=000000 -> State 000,001,010,100,000; ALUop=000 and RegDst=10; RegWre=PCWre=1 only in WB.
REQ-018 lw: Opcode=110001 -> IF,ID,EXE,MEM,WB (5 cycles); mRD=1 in MEM only; WB has DBDataSrc=1, RegDst=01, ALUSrcB=1.
REQ-019 beq/bne: Opcode=110100 with zero=1 -> PCSrc=01, PCWre=1 in EXE, 3 cycles total; Opcode=110101 with zero=1 -> PCSrc=00.
REQ-020 jal: Opcode=111010 -> in ID, PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0; next State=000.
REQ-021 halt: Opcode=111111 -> State stays 001 with PCWre=0 for 20 cycles; Reset=1 for one cycle -> State=000.
REQ-022 Mid-op reset: Reset asserted in MEM of sw -> mWR=0 that cycle, next State=000.
